// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and data access (DM).
// DM wins by default; a saturating streak counter hands the port to a waiting IF.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_SHIFT   = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_wen,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_IF = 2'd1,
    SERVE_DM = 2'd2,
    ACK      = 2'd3
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      r_state;
  state_t      w_state_next;

  logic        r_owner_dm;
  logic        r_is_store;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_streak;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;

  logic        w_grant_if;
  logic        w_grant_dm;
  logic        w_starving;
  logic [3:0]  w_streak_next;
  logic [31:0] w_req_addr;
  logic        w_mem_ren;
  logic        w_mem_wen;
  logic [31:0] w_mem_addr;
  logic [31:0] w_mem_din;
  logic        w_if_ack;
  logic        w_dm_ack;

  // IF only overrides DM once DM has won STARVE_LIMIT times in a row against it.
  assign w_starving = if_req && dm_req && (r_streak == LIMIT);
  assign w_req_addr = w_grant_dm ? dm_addr : if_addr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_grant_if    = 1'b0;
    w_grant_dm    = 1'b0;
    w_streak_next = r_streak;
    w_mem_ren     = 1'b0;
    w_mem_wen     = 1'b0;
    w_mem_addr    = 32'd0;
    w_mem_din     = 32'd0;
    w_if_ack      = 1'b0;
    w_dm_ack      = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_starving || (if_req && !dm_req)) begin
          w_grant_if    = 1'b1;
          w_streak_next = 4'd0;
          w_state_next  = SERVE_IF;
        end else if (dm_req) begin
          w_grant_dm   = 1'b1;
          w_state_next = SERVE_DM;
          if (!if_req) begin
            w_streak_next = 4'd0;
          end else if (r_streak != LIMIT) begin
            w_streak_next = r_streak + 4'd1;
          end
        end
      end
      SERVE_IF: begin
        w_mem_ren    = 1'b1;
        w_mem_addr   = r_addr;
        w_state_next = ACK;
      end
      SERVE_DM: begin
        w_mem_ren    = !r_is_store;
        w_mem_wen    = r_is_store;
        w_mem_addr   = r_addr;
        w_mem_din    = r_is_store ? r_wdata : 32'd0;
        w_state_next = ACK;
      end
      ACK: begin
        w_if_ack     = !r_owner_dm;
        w_dm_ack     = r_owner_dm;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_owner_dm <= 1'b0;
      r_is_store <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_streak   <= 4'd0;
      r_if_rdata <= 32'd0;
      r_dm_rdata <= 32'd0;
    end else begin
      r_streak <= w_streak_next;
      if (w_grant_if || w_grant_dm) begin
        r_owner_dm <= w_grant_dm;
        r_addr     <= w_req_addr >> ADDR_SHIFT;
        r_is_store <= w_grant_dm && dm_wen;
      end
      if (w_grant_dm && dm_wen) begin
        r_wdata <= dm_wdata;
      end
      // Read data is taken at the end of the serve cycle so it is valid alongside ack.
      if (r_state == SERVE_IF) begin
        r_if_rdata <= mem_dout;
      end
      if ((r_state == SERVE_DM) && !r_is_store) begin
        r_dm_rdata <= mem_dout;
      end
    end
  end

  assign mem_ren  = w_mem_ren;
  assign mem_wen  = w_mem_wen;
  assign mem_addr = w_mem_addr;
  assign mem_din  = w_mem_din;
  assign if_ack   = w_if_ack;
  assign dm_ack   = w_dm_ack;
  assign if_rdata = r_if_rdata;
  assign dm_rdata = r_dm_rdata;

endmodule
